// File: rtl/lightgun_latch_arb_if.sv
// VDP2 external HV-counter latch handshake shared by the light gun arbiter
// (master) and the VDP2 latch logic (slave).
interface lightgun_latch_arb_if;
  logic LATCH_REQ;
  logic LATCH_PORT;
  logic LATCH_ACK;

  modport master (
    output LATCH_REQ,
    output LATCH_PORT,
    input  LATCH_ACK
  );

  modport slave (
    input  LATCH_REQ,
    input  LATCH_PORT,
    output LATCH_ACK
  );
endinterface

// File: rtl/lightgun_latch_arb.sv
// Arbitrates the single VDP2 EXLT latch between two light gun ports: one latch
// per gun per frame, alternating priority, TH_N held low for HOLD_PIX pixels.
module lightgun_latch_arb #(
  parameter int unsigned HOLD_PIX = 16,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        CE_PIX,
  input  logic                        VDE,
  input  logic [1:0]                  EN,
  input  logic [1:0]                  SENSOR,
  input  logic                        EXLT_EN,
  lightgun_latch_arb_if.master        vdp,
  output logic [1:0]                  TH_N,
  output logic [1:0]                  DONE,
  output logic                        ERR
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_PIX);
  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state, state_n;
  logic [1:0]  s_d;
  logic        vde_d;
  logic [1:0]  pend, pend_n;
  logic [1:0]  done_n;
  logic        prio;
  logic        sel, sel_n;
  logic [7:0]  hold_cnt;
  logic [9:0]  tmo_cnt;

  logic        frame_start;
  logic [1:0]  edge_set;
  logic        start, grant, abandon, rel_th;

  always_comb begin
    frame_start = VDE & ~vde_d;
    edge_set    = SENSOR & ~s_d & EN & ~DONE;

    state_n = state;
    sel_n   = sel;
    start   = 1'b0;
    grant   = 1'b0;
    abandon = 1'b0;
    rel_th  = 1'b0;

    case (state)
      IDLE: begin
        if (EXLT_EN && (|pend)) begin
          start   = 1'b1;
          state_n = REQ;
          sel_n   = (&pend) ? prio : pend[1];
        end
      end
      REQ: begin
        // Ack outranks timeout, which outranks a plain disable
        if (vdp.LATCH_ACK) begin
          grant   = 1'b1;
          state_n = HOLD;
        end else if (tmo_cnt >= TMO_LIMIT) begin
          abandon = 1'b1;
          state_n = IDLE;
        end else if (!EXLT_EN) begin
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (CE_PIX && (hold_cnt <= 8'd1)) begin
          rel_th  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    pend_n = pend | edge_set;
    if (grant || abandon) pend_n[sel] = 1'b0;
    if (frame_start) pend_n = '0;

    done_n = DONE;
    if (grant) done_n[sel] = 1'b1;
    if (frame_start) done_n = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s_d      <= '0;
      vde_d    <= 1'b0;
      pend     <= '0;
      DONE     <= '0;
      prio     <= 1'b0;
      sel      <= 1'b0;
      hold_cnt <= '0;
      tmo_cnt  <= '0;
      TH_N     <= '1;
      ERR      <= 1'b0;
    end else begin
      s_d   <= SENSOR;
      vde_d <= VDE;
      pend  <= pend_n;
      DONE  <= done_n;
      sel   <= sel_n;
      ERR   <= abandon;

      if (grant) prio <= ~sel;

      if (start)
        tmo_cnt <= '0;
      else if (state == REQ && tmo_cnt != '1)
        tmo_cnt <= tmo_cnt + 10'd1;

      if (grant)
        hold_cnt <= HOLD_LOAD;
      else if (state == HOLD && CE_PIX && hold_cnt != '0)
        hold_cnt <= hold_cnt - 8'd1;

      if (grant)
        TH_N[sel] <= 1'b0;
      else if (rel_th)
        TH_N <= '1;
    end
  end

  // REQ state is itself registered, so the request line is a clean register decode
  assign vdp.LATCH_REQ  = (state == REQ);
  assign vdp.LATCH_PORT = sel;

endmodule
